// File: rtl/cipher_out_fifo.sv
// cipher_out_fifo: ciphertext capture FIFO with first-word fall-through and a valid/ready drain.
// Optional feature macro CIPHER_CKSUM_EN builds a running XOR checksum of popped bytes.
module cipher_out_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic [DATA_W-1:0] cksum
);

  localparam logic [ADDR_W:0]   FULL_CNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              overflow_q, overflow_d;
  logic              push, pop, drop, clear;

  assign clear     = reset | flush;
  assign empty     = (count_q == '0);
  assign full      = (count_q == FULL_CNT);
  assign out_valid = !empty;
  assign out_data  = mem_q[rd_ptr_q];
  assign count     = count_q;
  assign overflow  = overflow_q;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign pop  = out_valid & out_ready;
  assign push = wr_en & (!full | pop);
  assign drop = wr_en & full & !pop;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q | drop;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage is never cleared; a flush or reset simply discards it via the pointers.
  always_ff @(posedge clk) begin
    if (push && !clear) mem_q[wr_ptr_q] <= wr_data;
  end

`ifdef CIPHER_CKSUM_EN
  logic [DATA_W-1:0] cksum_q, cksum_d;

  assign cksum_d = pop ? (cksum_q ^ out_data) : cksum_q;

  always_ff @(posedge clk) begin
    if (clear) cksum_q <= '0;
    else       cksum_q <= cksum_d;
  end

  assign cksum = cksum_q;
`else
  assign cksum = '0;
`endif

endmodule

// File: tb/tb_cipher_out_fifo.sv
// Directed table-driven bench for cipher_out_fifo, plus hand sequences for the timing corners.
module tb_cipher_out_fifo;

`ifdef CIPHER_CKSUM_EN
  localparam bit CK_EN = 1'b1;
`else
  localparam bit CK_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       flush = 1'b0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_data;
  logic [3:0] count;
  logic       full, empty, overflow;
  logic [7:0] cksum;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cipher_out_fifo #(.DATA_W(8), .DEPTH(8), .ADDR_W(3)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .count(count), .full(full), .empty(empty), .overflow(overflow), .cksum(cksum)
  );

  typedef struct {
    logic       rst;
    logic       fl;
    logic       we;
    logic [7:0] wd;
    logic       rdy;
    logic [7:0] dout;
    logic [3:0] cnt;
    logic       ovf;
    logic [7:0] ck;
    int         tid;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic rst, input logic fl, input logic we,
                              input logic [7:0] wd, input logic rdy, input logic [7:0] dout,
                              input logic [3:0] cnt, input logic ovf, input logic [7:0] ck,
                              input int tid);
    vec_t v;
    v.rst = rst; v.fl = fl; v.we = we; v.wd = wd; v.rdy = rdy;
    v.dout = dout; v.cnt = cnt; v.ovf = ovf; v.ck = ck; v.tid = tid;
    vq.push_back(v);
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s[%0d] actual=%h required=%h", nm, idx, act, exp);
    end
  endtask

  logic [7:0] ck;

  initial begin
    // Test 1 and checksum sequence: 0x41 then 0x13 popped -> 0x52
    add(1, 0, 0, 8'h00, 0, 8'h00, 4'd0, 0, 8'h00, 1);
    add(0, 0, 1, 8'h41, 0, 8'h41, 4'd1, 0, 8'h00, 1);
    add(0, 0, 0, 8'h00, 1, 8'h00, 4'd0, 0, 8'h41, 6);
    add(0, 0, 1, 8'h13, 0, 8'h13, 4'd1, 0, 8'h41, 6);
    add(0, 0, 0, 8'h00, 1, 8'h00, 4'd0, 0, 8'h52, 6);
    ck = 8'h52;
    // Test 2: fill 0x10..0x17
    for (int i = 0; i < 8; i++)
      add(0, 0, 1, 8'h10 + 8'(i), 0, 8'h10, 4'(i + 1), 0, ck, 2);
    // Test 3: dropped push while full
    add(0, 0, 1, 8'hAA, 0, 8'h10, 4'd8, 1, ck, 3);
    // Drain in order; 0xAA must never appear, overflow stays sticky
    for (int i = 0; i < 8; i++) begin
      ck = ck ^ (8'h10 + 8'(i));
      add(0, 0, 0, 8'h00, 1, 8'h11 + 8'(i), 4'(7 - i), 1, ck, 2);
    end
    // Flush beats a push in the same cycle
    add(0, 1, 1, 8'h99, 1, 8'h00, 4'd0, 0, 8'h00, 3);
    // Test 4: fill 0x20..0x27, then push 0x55 with a simultaneous pop
    for (int i = 0; i < 8; i++)
      add(0, 0, 1, 8'h20 + 8'(i), 0, 8'h20, 4'(i + 1), 0, 8'h00, 4);
    ck = 8'h20;
    add(0, 0, 1, 8'h55, 1, 8'h21, 4'd8, 0, ck, 4);
    for (int i = 1; i < 8; i++) begin
      ck = ck ^ (8'h20 + 8'(i));
      add(0, 0, 0, 8'h00, 1, (i == 7) ? 8'h55 : 8'h21 + 8'(i), 4'(8 - i), 0, ck, 4);
    end
    ck = ck ^ 8'h55;
    add(0, 0, 0, 8'h00, 1, 8'h00, 4'd0, 0, ck, 4);
    add(1, 0, 0, 8'h00, 0, 8'h00, 4'd0, 0, 8'h00, 7);
    // Test 5: streaming 0x00..0x13 with pointer wrap
    ck = 8'h00;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) ck = ck ^ 8'(k - 1);
      add(0, 0, 1, 8'(k), 1, 8'(k), 4'd1, 0, ck, 5);
    end
    ck = ck ^ 8'h13;
    add(0, 0, 0, 8'h00, 1, 8'h00, 4'd0, 0, ck, 5);
    // Sticky overflow survives idle, cleared by reset mid-stream (reset beats push)
    add(1, 0, 0, 8'h00, 0, 8'h00, 4'd0, 0, 8'h00, 8);
    for (int i = 0; i < 8; i++)
      add(0, 0, 1, 8'h30 + 8'(i), 0, 8'h30, 4'(i + 1), 0, 8'h00, 8);
    add(0, 0, 1, 8'hBB, 0, 8'h30, 4'd8, 1, 8'h00, 8);
    add(0, 0, 0, 8'h00, 0, 8'h30, 4'd8, 1, 8'h00, 8);
    add(1, 0, 1, 8'hCC, 1, 8'h00, 4'd0, 0, 8'h00, 8);

    for (int n = 0; n < vq.size(); n++) begin
      @(negedge clk);
      reset = vq[n].rst; flush = vq[n].fl; wr_en = vq[n].we;
      wr_data = vq[n].wd; out_ready = vq[n].rdy;
      @(posedge clk);
      #1;
      chk("count", n, 32'(count), 32'(vq[n].cnt));
      chk("out_valid", n, 32'(out_valid), 32'(vq[n].cnt != 4'd0));
      chk("empty", n, 32'(empty), 32'(vq[n].cnt == 4'd0));
      chk("full", n, 32'(full), 32'(vq[n].cnt == 4'd8));
      chk("overflow", n, 32'(overflow), 32'(vq[n].ovf));
      chk("cksum", n, 32'(cksum), CK_EN ? 32'(vq[n].ck) : 32'h0);
      if (vq[n].cnt != 4'd0)
        chk("out_data", n, 32'(out_data), 32'(vq[n].dout));
    end

    // No bypass: a push into an empty FIFO is not visible until the next cycle
    @(negedge clk);
    reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
    wr_en = 1'b1; wr_data = 8'h7E;
    #1;
    chk("nobypass_valid", 0, 32'(out_valid), 32'h0);
    chk("nobypass_count", 0, 32'(count), 32'h0);
    @(posedge clk);
    #1;
    chk("fwft_valid", 0, 32'(out_valid), 32'h1);
    chk("fwft_data", 0, 32'(out_data), 32'h7E);
    // Ready is presented mid-cycle; the pop only lands on the edge
    @(negedge clk);
    wr_en = 1'b0; out_ready = 1'b1;
    #1;
    chk("prepop_valid", 0, 32'(out_valid), 32'h1);
    @(posedge clk);
    #1;
    chk("postpop_empty", 0, 32'(empty), 32'h1);
    chk("postpop_cksum", 0, 32'(cksum), CK_EN ? 32'h7E : 32'h0);
    // Ready while empty is ignored for several cycles
    repeat (3) @(posedge clk);
    #1;
    chk("idle_count", 0, 32'(count), 32'h0);
    chk("idle_cksum", 0, 32'(cksum), CK_EN ? 32'h7E : 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
